// File: rtl/mux_arbiter_4to1_pkg.sv
// Shared types, constants and the round-robin pick helper for mux_arbiter_4to1.
package mux_arbiter_4to1_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  // Arbiter FSM: IDLE picks a new owner, LOCKED keeps the current one.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Result of a round-robin scan.
  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester with req set, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The loop runs from the farthest offset down, so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res.valid = 1'b0;
    res.idx   = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_arbiter_4to1_mux.sv
// Plain N-bit 4-to-1 multiplexer shared by the four requesters.
module mux_Nbit_4to1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Select one of the four slots by index.
  always_comb begin
    y = '0;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      2'd3:    y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux_arbiter_4to1.sv
// Round-robin packet arbiter in front of a shared 4-to-1 mux with a
// registered single-beat output stage toward one downstream consumer.
module mux_arbiter_4to1
  import mux_arbiter_4to1_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ-1:0]       in_last,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [SEL_W-1:0]  owner_r;
  logic [SEL_W-1:0]  ptr_r;

  logic              out_valid_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              out_last_r;
  logic [SEL_W-1:0]  out_sel_r;

  pick_t             pick_s;
  logic              grant_valid_s;
  logic [SEL_W-1:0]  g_s;
  logic              slot_free_s;
  logic [N_REQ-1:0]  in_ready_s;
  logic              xfer_s;
  logic              xfer_last_s;
  logic [WIDTH-1:0]  mux_y_s;

  // Grant selection: the locked owner, otherwise the round-robin winner.
  always_comb begin
    pick_s        = rr_pick(in_valid, ptr_r);
    grant_valid_s = 1'b0;
    g_s           = 2'd0;
    case (state_r)
      IDLE: begin
        grant_valid_s = pick_s.valid;
        g_s           = pick_s.idx;
      end
      LOCKED: begin
        grant_valid_s = 1'b1;
        g_s           = owner_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        g_s           = 2'd0;
      end
    endcase
  end

  // Handshake: a full output register may drain and refill in one cycle,
  // so out_ready passes straight through to the granted in_ready bit.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    in_ready_s  = 4'b0000;
    if (!rst && slot_free_s && grant_valid_s) begin
      in_ready_s = 4'b0001 << g_s;
    end else begin
      in_ready_s = 4'b0000;
    end
    xfer_s      = in_valid[g_s] && in_ready_s[g_s];
    xfer_last_s = in_last[g_s];
  end

  // Next-state logic: a transferred last beat releases the lock.
  always_comb begin
    state_nxt_s = state_r;
    if (xfer_s) begin
      if (xfer_last_s) begin
        state_nxt_s = IDLE;
      end else begin
        state_nxt_s = LOCKED;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= 2'd0;
      ptr_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (xfer_s && xfer_last_s) begin
        ptr_r   <= g_s + 2'd1;
        owner_r <= owner_r;
      end else if (xfer_s) begin
        ptr_r   <= ptr_r;
        owner_r <= g_s;
      end else begin
        ptr_r   <= ptr_r;
        owner_r <= owner_r;
      end
    end
  end

  mux_Nbit_4to1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a  (in_data[0*WIDTH +: WIDTH]),
    .b  (in_data[1*WIDTH +: WIDTH]),
    .c  (in_data[2*WIDTH +: WIDTH]),
    .d  (in_data[3*WIDTH +: WIDTH]),
    .sel(g_s),
    .y  (mux_y_s)
  );

  // Output register: load on transfer, empty on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_sel_r   <= 2'd0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mux_y_s;
      out_last_r  <= xfer_last_s;
      out_sel_r   <= g_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_last_r  <= out_last_r;
      out_sel_r   <= out_sel_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_last_r  <= out_last_r;
      out_sel_r   <= out_sel_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux_arbiter_4to1.sv
// Directed self-checking bench for mux_arbiter_4to1 (WIDTH = 4).
module tb_mux_arbiter_4to1;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int total;
  int bad;

  mux_arbiter_4to1 #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and step 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                         input logic l, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  logic [3:0] rr_data [4];

  initial begin
    total     = 0;
    bad       = 0;
    rr_data[0] = 4'hA;
    rr_data[1] = 4'hB;
    rr_data[2] = 4'hC;
    rr_data[3] = 4'hD;

    // ---- reset, with every requester valid: in_ready must stay 0
    rst = 1'b1; in_valid = 4'hF; in_last = 4'hF; in_data = 16'h0000; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("rst_in_ready2", 32'(in_ready), 32'h0);
    tick();
    chk_out("rst_out", 1'b0, 4'h0, 1'b0, 2'd0);

    // ---- idle for 10 cycles
    rst = 1'b0; in_valid = 4'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 32'(out_valid), 32'h0);
    end

    // ---- round-robin: single-beat packets from all four, 10 beats
    in_valid = 4'hF; in_last = 4'hF; in_data = 16'hDCBA; out_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("rr", 1'b1, rr_data[i % 4], 1'b1, 2'(i % 4));
    end
    // ptr is now 2

    // ---- packet lock: requester 2 sends 3 beats, requester 0 waits
    in_valid = 4'b0101;
    in_data  = 16'h0105;  // slot2=1, slot0=5
    in_last  = 4'b0001;
    #1;
    chk("lock_b1_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("lock_b1", 1'b1, 4'h1, 1'b0, 2'd2);
    in_data = 16'h0205;
    #1;
    chk("lock_b2_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("lock_b2", 1'b1, 4'h2, 1'b0, 2'd2);
    in_data = 16'h0305; in_last = 4'b0101;
    #1;
    chk("lock_b3_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("lock_b3", 1'b1, 4'h3, 1'b1, 2'd2);
    #1;
    chk("lock_after_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("lock_then0", 1'b1, 4'h5, 1'b1, 2'd0);
    // ptr is now 1

    // ---- backpressure: hold 7 for 5 stalled cycles, then 8 replaces it
    in_valid = 4'b0010; in_last = 4'b0010; in_data = 16'h0070;
    tick();
    chk_out("bp_load", 1'b1, 4'h7, 1'b1, 2'd1);
    out_ready = 1'b0; in_data = 16'h0080;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 4'h7, 1'b1, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("bp_next", 1'b1, 4'h8, 1'b1, 2'd1);
    in_valid = 4'h0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'h0);
    // ptr is now 2

    // ---- owner gap: requester 1 locks, goes quiet, requester 3 must wait
    in_valid = 4'b0010; in_last = 4'b0000; in_data = 16'hE090;
    tick();
    chk_out("gap_b1", 1'b1, 4'h9, 1'b0, 2'd1);
    in_valid = 4'b1000; in_last = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gap_ready", 32'(in_ready), 32'h2);
      tick();
      chk("gap_no_out", 32'(out_valid), 32'h0);
    end
    in_valid = 4'b1010; in_last = 4'b1010; in_data = 16'hE0A0;
    #1;
    chk("gap_resume_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("gap_b2", 1'b1, 4'hA, 1'b1, 2'd1);
    in_valid = 4'b1000;
    #1;
    chk("gap_to3_ready", 32'(in_ready), 32'h8);
    tick();
    chk_out("gap_3", 1'b1, 4'hE, 1'b1, 2'd3);
    // ptr is now 0

    // ---- reset mid-packet while locked on owner 3
    in_valid = 4'b1000; in_last = 4'b0000; in_data = 16'h6000;
    tick();
    chk_out("mid_lock3", 1'b1, 4'h6, 1'b0, 2'd3);
    rst = 1'b1; in_valid = 4'b1010; in_data = 16'h6030;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("mid_rst_out", 1'b0, 4'h0, 1'b0, 2'd0);
    rst = 1'b0; in_last = 4'b1010;
    #1;
    chk("mid_after_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("mid_after", 1'b1, 4'h3, 1'b1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
